// File: rtl/result_stream_tx_if.sv
// AXI4-Stream bundle carrying extended result elements.
// master drives data/valid/last, slave returns ready.
interface result_stream_tx_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/result_stream_tx.sv
// Snapshots a core result matrix and streams it out
// element by element over AXI4-Stream, one frame per capture.
module result_stream_tx #(
  parameter int SIZE       = 8,
  parameter int DATA_WIDTH = 4,
  parameter bit SIGNED     = 1
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [SIZE*SIZE*3*DATA_WIDTH-1:0] result_matrix,
  input  logic                result_capture,
  result_stream_tx_if.master  m_axis,
  output logic                busy,
  output logic                frame_done,
  output logic [7:0]          drop_count
);
  localparam int RES_W = 3 * DATA_WIDTH;
  localparam int N     = SIZE * SIZE;
  localparam int IW    = $clog2(N) + 1;
  localparam int AW    = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  state_e                    state_q, state_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic                      done_q, done_d;
  logic [7:0]                drop_q, drop_d;
  logic [N-1:0][RES_W-1:0]   shadow_q;
  logic                      load;
  logic                      fire;
  logic                      last;
  logic [RES_W-1:0]          elem;

  assign last = (state_q == SEND) &&
                (idx_q == IW'(N - 1));
  assign fire = m_axis.tvalid && m_axis.tready;
  assign elem = shadow_q[idx_q[AW-1:0]];

  assign m_axis.tvalid = (state_q == SEND);
  assign m_axis.tlast  = last;
  assign busy          = (state_q == SEND);
  assign frame_done    = done_q;
  assign drop_count    = drop_q;

  // Outputs come only from the shadow copy, never the live matrix.
  always_comb begin
    m_axis.tdata = '0;
    if (state_q == SEND) begin
      if (SIGNED) m_axis.tdata = 32'($signed(elem));
      else        m_axis.tdata = 32'(elem);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    drop_d  = drop_q;
    load    = 1'b0;
    unique case (1'b1)
      state_q == IDLE: begin
        if (result_capture) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      state_q == SEND: begin
        if (result_capture && drop_q != 8'hFF)
          drop_d = drop_q + 8'd1;
        if (fire) begin
          if (last) begin
            state_d = IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (load) shadow_q <= result_matrix;
  end
endmodule

// File: tb/tb_result_stream_tx.sv
// Self-checking bench for result_stream_tx (SIZE=2),
// signed and unsigned instances sharing stimulus.
module tb_result_stream_tx;
  localparam int SIZE = 2;
  localparam int DW   = 4;
  localparam int RW   = 12;
  localparam int N    = 4;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          result_capture = 1'b0;
  logic          tready = 1'b0;
  logic [N*RW-1:0] result_matrix = '0;
  logic          busy_s, busy_u;
  logic          done_s, done_u;
  logic [7:0]    drop_s, drop_u;
  int            checks = 0;
  int            failures = 0;

  result_stream_tx_if axs();
  result_stream_tx_if axu();
  assign axs.tready = tready;
  assign axu.tready = tready;

  always #5 aclk = ~aclk;

  result_stream_tx #(
    .SIZE(SIZE), .DATA_WIDTH(DW), .SIGNED(1)
  ) dut_s (
    .aclk(aclk), .aresetn(aresetn),
    .result_matrix(result_matrix),
    .result_capture(result_capture),
    .m_axis(axs), .busy(busy_s),
    .frame_done(done_s), .drop_count(drop_s)
  );

  result_stream_tx #(
    .SIZE(SIZE), .DATA_WIDTH(DW), .SIGNED(0)
  ) dut_u (
    .aclk(aclk), .aresetn(aresetn),
    .result_matrix(result_matrix),
    .result_capture(result_capture),
    .m_axis(axu), .busy(busy_u),
    .frame_done(done_u), .drop_count(drop_u)
  );

  function automatic logic [31:0] ext_s(input logic [RW-1:0] e);
    int v;
    v = int'(e);
    if (v >= 2 ** (RW - 1)) v = v - 2 ** RW;
    return 32'(v);
  endfunction

  function automatic logic [31:0] ext_u(input logic [RW-1:0] e);
    return 32'(int'(e));
  endfunction

  function automatic logic [N*RW-1:0] pack(input logic [RW-1:0] a [N]);
    logic [N*RW-1:0] r;
    for (int k = 0; k < N; k++) r[k*RW +: RW] = a[k];
    return r;
  endfunction

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic rand_mat(output logic [RW-1:0] a [N]);
    for (int k = 0; k < N; k++) a[k] = RW'($urandom);
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    tready  = 1'b1;
    step();
    step();
    checks++; if (axs.tvalid !== 1'b0) begin failures++; $display("FAIL rst_tvalid got=%b exp=0", axs.tvalid); end
    checks++; if (axs.tlast !== 1'b0) begin failures++; $display("FAIL rst_tlast got=%b exp=0", axs.tlast); end
    checks++; if (axs.tdata !== 32'h0) begin failures++; $display("FAIL rst_tdata got=%h exp=0", axs.tdata); end
    checks++; if (busy_s !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy_s); end
    checks++; if (done_s !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done_s); end
    checks++; if (drop_s !== 8'd0) begin failures++; $display("FAIL rst_drop got=%0d exp=0", drop_s); end
    aresetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (axs.tvalid !== 1'b0 || axu.tvalid !== 1'b0) begin failures++; $display("FAIL idle_tready tvalid got=%b/%b exp=0", axs.tvalid, axu.tvalid); end
    end
  endtask

  task automatic test_basic();
    logic [RW-1:0] m [N];
    logic [31:0]   es [N];
    logic [31:0]   eu [N];
    m  = '{12'h001, 12'hFFF, 12'h7FF, 12'h800};
    es = '{32'h00000001, 32'hFFFFFFFF, 32'h000007FF, 32'hFFFFF800};
    eu = '{32'h00000001, 32'h00000FFF, 32'h000007FF, 32'h00000800};
    result_matrix  = pack(m);
    tready         = 1'b1;
    result_capture = 1'b1;
    step();
    result_capture = 1'b0;
    for (int i = 0; i < N; i++) begin
      checks++; if (axs.tvalid !== 1'b1) begin failures++; $display("FAIL basic_tvalid[%0d] got=%b exp=1", i, axs.tvalid); end
      checks++; if (axs.tdata !== es[i]) begin failures++; $display("FAIL basic_sdata[%0d] got=%h exp=%h", i, axs.tdata, es[i]); end
      checks++; if (axu.tdata !== eu[i]) begin failures++; $display("FAIL basic_udata[%0d] got=%h exp=%h", i, axu.tdata, eu[i]); end
      checks++; if (axs.tlast !== (i == N - 1)) begin failures++; $display("FAIL basic_tlast[%0d] got=%b", i, axs.tlast); end
      step();
    end
    checks++; if (axs.tvalid !== 1'b0) begin failures++; $display("FAIL basic_end_tvalid got=%b exp=0", axs.tvalid); end
    checks++; if (done_s !== 1'b1 || done_u !== 1'b1) begin failures++; $display("FAIL basic_done got=%b/%b exp=1", done_s, done_u); end
    checks++; if (busy_s !== 1'b0) begin failures++; $display("FAIL basic_busy got=%b exp=0", busy_s); end
    step();
    checks++; if (done_s !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", done_s); end
  endtask

  task automatic test_backpressure();
    logic [RW-1:0] m [N];
    logic [RW-1:0] junk [N];
    bit            pat [7];
    int            beats;
    pat = '{1, 0, 0, 1, 0, 1, 1};
    rand_mat(m);
    result_matrix  = pack(m);
    result_capture = 1'b1;
    tready         = 1'b0;
    step();
    result_capture = 1'b0;
    beats = 0;
    for (int j = 0; j < 7; j++) begin
      checks++; if (axs.tvalid !== 1'b1) begin failures++; $display("FAIL bp_tvalid[%0d] got=%b exp=1", j, axs.tvalid); end
      checks++; if (axs.tdata !== ext_s(m[beats])) begin failures++; $display("FAIL bp_sdata[%0d] got=%h exp=%h", j, axs.tdata, ext_s(m[beats])); end
      checks++; if (axu.tdata !== ext_u(m[beats])) begin failures++; $display("FAIL bp_udata[%0d] got=%h exp=%h", j, axu.tdata, ext_u(m[beats])); end
      checks++; if (axs.tlast !== (beats == N - 1)) begin failures++; $display("FAIL bp_tlast[%0d] got=%b", j, axs.tlast); end
      tready = pat[j];
      rand_mat(junk);
      result_matrix = pack(junk);
      if (pat[j]) beats++;
      step();
    end
    checks++; if (axs.tvalid !== 1'b0) begin failures++; $display("FAIL bp_end_tvalid got=%b exp=0", axs.tvalid); end
    checks++; if (done_s !== 1'b1) begin failures++; $display("FAIL bp_done got=%b exp=1", done_s); end
    tready = 1'b1;
  endtask

  task automatic test_drop();
    logic [RW-1:0] m [N];
    aresetn = 1'b0;
    step();
    aresetn = 1'b1;
    rand_mat(m);
    result_matrix  = pack(m);
    result_capture = 1'b1;
    tready         = 1'b0;
    step();
    step();
    result_capture = 1'b0;
    tready         = 1'b1;
    for (int i = 0; i < N; i++) begin
      checks++; if (axs.tdata !== ext_s(m[i])) begin failures++; $display("FAIL drop_data[%0d] got=%h exp=%h", i, axs.tdata, ext_s(m[i])); end
      result_capture = (i == N - 1);
      step();
    end
    result_capture = 1'b0;
    checks++; if (drop_s !== 8'd2) begin failures++; $display("FAIL drop_two got=%0d exp=2", drop_s); end
    checks++; if (axs.tvalid !== 1'b0) begin failures++; $display("FAIL drop_no_frame got=%b exp=0", axs.tvalid); end
    step();
    checks++; if (axs.tvalid !== 1'b0) begin failures++; $display("FAIL drop_no_frame2 got=%b exp=0", axs.tvalid); end
    tready         = 1'b0;
    result_capture = 1'b1;
    step();
    for (int k = 1; k <= 300; k++) begin
      step();
      if (k == 100) begin
        checks++; if (drop_s !== 8'd102) begin failures++; $display("FAIL drop_mid got=%0d exp=102", drop_s); end
      end
    end
    checks++; if (drop_s !== 8'd255) begin failures++; $display("FAIL drop_sat got=%0d exp=255", drop_s); end
    result_capture = 1'b0;
    tready         = 1'b1;
    repeat (N) step();
    checks++; if (axs.tvalid !== 1'b0 || drop_s !== 8'd255) begin failures++; $display("FAIL drop_drain tvalid=%b drop=%0d exp=0/255", axs.tvalid, drop_s); end
  endtask

  task automatic test_reset_midframe();
    logic [RW-1:0] m [N];
    rand_mat(m);
    result_matrix  = pack(m);
    tready         = 1'b1;
    result_capture = 1'b1;
    step();
    result_capture = 1'b0;
    step();
    step();
    aresetn = 1'b0;
    step();
    checks++; if (axs.tvalid !== 1'b0 || axs.tlast !== 1'b0) begin failures++; $display("FAIL mrst_tvalid got=%b/%b exp=0", axs.tvalid, axs.tlast); end
    checks++; if (busy_s !== 1'b0) begin failures++; $display("FAIL mrst_busy got=%b exp=0", busy_s); end
    checks++; if (drop_s !== 8'd0) begin failures++; $display("FAIL mrst_drop got=%0d exp=0", drop_s); end
    aresetn = 1'b1;
    step();
    step();
    checks++; if (axs.tvalid !== 1'b0) begin failures++; $display("FAIL mrst_after got=%b exp=0", axs.tvalid); end
    rand_mat(m);
    result_matrix  = pack(m);
    result_capture = 1'b1;
    step();
    result_capture = 1'b0;
    for (int i = 0; i < N; i++) begin
      checks++; if (axs.tdata !== ext_s(m[i]) || axs.tvalid !== 1'b1) begin failures++; $display("FAIL mrst_data[%0d] got=%h exp=%h", i, axs.tdata, ext_s(m[i])); end
      step();
    end
    checks++; if (done_s !== 1'b1) begin failures++; $display("FAIL mrst_done got=%b exp=1", done_s); end
  endtask

  task automatic test_random();
    logic [RW-1:0] m [N];
    logic [RW-1:0] junk [N];
    int beats;
    int cyc;
    for (int f = 0; f < 20; f++) begin
      rand_mat(m);
      result_matrix  = pack(m);
      result_capture = 1'b1;
      tready         = 1'($urandom);
      step();
      result_capture = 1'b0;
      beats = 0;
      cyc   = 0;
      while (beats < N && cyc < 200) begin
        checks++; if (axs.tvalid !== 1'b1 || busy_s !== 1'b1) begin failures++; $display("FAIL rnd_tvalid f=%0d got=%b exp=1", f, axs.tvalid); end
        checks++; if (axs.tdata !== ext_s(m[beats])) begin failures++; $display("FAIL rnd_sdata f=%0d b=%0d got=%h exp=%h", f, beats, axs.tdata, ext_s(m[beats])); end
        checks++; if (axu.tdata !== ext_u(m[beats])) begin failures++; $display("FAIL rnd_udata f=%0d b=%0d got=%h exp=%h", f, beats, axu.tdata, ext_u(m[beats])); end
        checks++; if (axs.tlast !== (beats == N - 1)) begin failures++; $display("FAIL rnd_tlast f=%0d b=%0d got=%b", f, beats, axs.tlast); end
        tready = 1'($urandom_range(0, 1));
        rand_mat(junk);
        result_matrix = pack(junk);
        if (tready) beats++;
        step();
        cyc++;
      end
      checks++; if (cyc >= 200) begin failures++; $display("FAIL rnd_timeout f=%0d beats=%0d exp=%0d", f, beats, N); end
      checks++; if (axs.tvalid !== 1'b0 || done_s !== 1'b1) begin failures++; $display("FAIL rnd_end f=%0d tvalid=%b done=%b exp=0/1", f, axs.tvalid, done_s); end
      tready = 1'($urandom);
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_drop();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/result_stream_tx.md
RESULT_STREAM_TX -- requirements
Module: result_stream_tx

Interface
REQ-001 The block SHALL have parameter SIZE, default 8, meaning array dimension; a frame holds SIZE*SIZE elements.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 4, meaning operand width; each result element is RES_W = 3*DATA_WIDTH bits.
REQ-003 The block SHALL have parameter SIGNED, default 1, meaning 1 = sign-extend elements to 32 bits, 0 = zero-extend.
REQ-004 aclk  input  1  clock; all logic on its rising edge.
REQ-005 aresetn  input  1  reset, synchronous, active-low.
REQ-006 result_matrix  input  SIZE*SIZE*RES_W  flattened core results; element k = bits [k*RES_W +: RES_W], k = row*SIZE+col.
REQ-007 result_capture  input  1  single-cycle pulse (core done) requesting transmission of result_matrix.
REQ-008 m_axis_tdata  output  32  extended result element.
REQ-009 m_axis_tvalid  output  1  AXI4-Stream valid.
REQ-010 m_axis_tready  input  1  AXI4-Stream ready from downstream.
REQ-011 m_axis_tlast  output  1  high on final element of a frame.
REQ-012 busy  output  1  high while a frame is pending or in transmission.
REQ-013 frame_done  output  1  one-cycle pulse after final beat accepted.
REQ-014 drop_count  output  8  saturating count of rejected captures.

Function
REQ-015 The block SHALL implement states IDLE and SEND.
REQ-016 In IDLE with result_capture=1, the block SHALL latch result_matrix into an internal shadow register, clear element index to 0, and enter SEND on the same edge.
REQ-017 m_axis_tvalid SHALL be high in the first cycle after capture (1-cycle latency) and remain high throughout SEND.
REQ-018 m_axis_tdata SHALL equal shadow element[index], extended per SIGNED, driven from registers or shadow only (no combinational path from result_matrix).
REQ-019 A beat SHALL transfer only when m_axis_tvalid and m_axis_tready are both high; index increments by 1 per transfer.
REQ-020 While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata, m_axis_tlast and m_axis_tvalid SHALL hold stable.
REQ-021 m_axis_tlast SHALL be high exactly when index = SIZE*SIZE-1 in SEND.
REQ-022 On transfer of the tlast beat, the block SHALL return to IDLE; m_axis_tvalid is low the next cycle and frame_done pulses high for exactly that cycle.
REQ-023 Shadow contents SHALL not change in SEND; result_matrix changes during SEND SHALL not affect the frame.
REQ-024 result_capture asserted while state is SEND (including the cycle the tlast beat transfers) SHALL be ignored and drop_count incremented, saturating at 255.
REQ-025 busy SHALL equal (state == SEND).
REQ-026 m_axis_tready asserted in IDLE SHALL have no effect.
REQ-027 Index width SHALL be $clog2(SIZE*SIZE)+1 bits or wider; no wrap-around within a frame.

Reset
REQ-028 With aresetn=0 at a rising edge, state SHALL become IDLE, index 0, m_axis_tvalid 0, m_axis_tlast 0, m_axis_tdata 0, busy 0, frame_done 0, drop_count 0.
REQ-029 Reset mid-frame SHALL abort the frame immediately; no further beats of that frame are emitted after reset deasserts.
REQ-030 Shadow register contents need not be reset.

Verification
REQ-031 SIZE=2, DATA_WIDTH=4, SIGNED=1, elements {0x001,0xFFF,0x7FF,0x800}, tready=1, capture pulse -> tdata 0x00000001, 0xFFFFFFFF, 0x000007FF, 0xFFFFF800 on 4 consecutive cycles starting 1 cycle after capture, tlast on 4th, frame_done next cycle.
REQ-032 Same frame with SIGNED=0 -> 0x00000001, 0x00000FFF, 0x000007FF, 0x00000800.
REQ-033 tready toggled 1,0,0,1,0,1,1 -> exactly 4 beats, tdata/tlast stable during stalls, order preserved, result_matrix changed mid-frame has no effect.
REQ-034 Capture pulse during SEND and on the tlast-transfer cycle -> both ignored, drop_count=2, only one frame emitted; 300 such captures -> drop_count=255.
REQ-035 aresetn low for 1 cycle after 2nd beat of a frame -> tvalid 0, busy 0, drop_count 0 next cycle; new capture then emits full frame from element 0.
